// File: rtl/pdm_output_stage.sv
// Multi-channel PDM output stage: ramped gain, 3-stage gain/offset pipeline,
// first-order sigma-delta modulators and an input-stall (underrun) detector.
module pdm_output_stage #(
  parameter int unsigned NCH       = 2,
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned VOL_WIDTH = 8,
  parameter int unsigned RAMP_DIV  = 64,
  parameter int unsigned TIMEOUT   = 4096
) (
  input  logic                   clk_in,
  input  logic                   rst_n_in,
  input  logic [NCH*WIDTH-1:0]   sample_in,
  input  logic                   valid_in,
  input  logic [VOL_WIDTH-1:0]   vol_in,
  input  logic                   mute_in,
  output logic [NCH-1:0]         d_out,
  output logic                   underrun_out
);

  localparam int unsigned PW   = WIDTH + VOL_WIDTH + 1;
  localparam int unsigned RC_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam int unsigned TO_W = $clog2(TIMEOUT + 1);
  localparam logic [WIDTH-1:0]     MID  = WIDTH'(1) << (WIDTH - 1);
  localparam logic signed [PW-1:0] SMAX = PW'((64'(1) << (WIDTH - 1)) - 64'(1));
  localparam logic signed [PW-1:0] SMIN = ~SMAX;

  logic [VOL_WIDTH-1:0]          g_q, g_d, target;
  logic [RC_W-1:0]               ramp_cnt_q, ramp_cnt_d;
  logic                          tick;
  logic [TO_W-1:0]               to_cnt_q, to_cnt_d;
  logic                          underrun_q, underrun_d;
  logic [NCH-1:0][WIDTH-1:0]     s1_q, s1_d;
  logic                          s1_vld_q, s1_vld_d;
  logic [NCH-1:0][PW-1:0]        s2_q, s2_d;
  logic                          s2_vld_q, s2_vld_d;
  logic [NCH-1:0][WIDTH-1:0]     u_q, u_d;
  logic [NCH-1:0][WIDTH-1:0]     acc_q, acc_d;
  logic [NCH-1:0]                d_q, d_d;

  // Signed sample times zero-extended gain, full precision.
  function automatic logic [PW-1:0] mul_gain(input logic [WIDTH-1:0] s,
                                             input logic [VOL_WIDTH-1:0] g);
    logic signed [PW-1:0] a;
    logic signed [PW-1:0] b;
    a = PW'($signed(s));
    b = PW'($signed({1'b0, g}));
    return a * b;
  endfunction

  // Remove unity-gain scaling, saturate, convert to offset binary.
  function automatic logic [WIDTH-1:0] to_code(input logic [PW-1:0] p);
    logic signed [PW-1:0] sh;
    logic signed [PW-1:0] sat;
    sh = $signed(p) >>> (VOL_WIDTH - 1);
    if (sh > SMAX)      sat = SMAX;
    else if (sh < SMIN) sat = SMIN;
    else                sat = sh;
    return WIDTH'(sat) + MID;
  endfunction

  always_comb begin
    target     = mute_in ? '0 : vol_in;
    tick       = (ramp_cnt_q == RC_W'(RAMP_DIV - 1));
    ramp_cnt_d = tick ? '0 : ramp_cnt_q + RC_W'(1);
    g_d        = g_q;
    if (tick) begin
      if (g_q < target)      g_d = g_q + VOL_WIDTH'(1);
      else if (g_q > target) g_d = g_q - VOL_WIDTH'(1);
    end

    // Stall counter saturates at TIMEOUT; a valid strobe always wins.
    to_cnt_d = to_cnt_q;
    if (valid_in)                          to_cnt_d = '0;
    else if (to_cnt_q != TO_W'(TIMEOUT))   to_cnt_d = to_cnt_q + TO_W'(1);
    underrun_d = (to_cnt_d == TO_W'(TIMEOUT));

    s1_vld_d = valid_in;
    s1_d     = valid_in ? sample_in : s1_q;
    s2_vld_d = s1_vld_q;
    s2_d     = s2_q;
    u_d      = u_q;
    acc_d    = acc_q;
    d_d      = d_q;
    for (int c = 0; c < NCH; c++) begin
      if (s1_vld_q) s2_d[c] = mul_gain(s1_q[c], g_q);
      if (underrun_d)    u_d[c] = MID;
      else if (s2_vld_q) u_d[c] = to_code(s2_q[c]);
      {d_d[c], acc_d[c]} = {1'b0, acc_q[c]} + {1'b0, u_q[c]};
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      g_q        <= '0;
      ramp_cnt_q <= '0;
      to_cnt_q   <= '0;
      underrun_q <= 1'b0;
      s1_q       <= '0;
      s1_vld_q   <= 1'b0;
      s2_q       <= '0;
      s2_vld_q   <= 1'b0;
      u_q        <= {NCH{MID}};
      acc_q      <= '0;
      d_q        <= '0;
    end else begin
      g_q        <= g_d;
      ramp_cnt_q <= ramp_cnt_d;
      to_cnt_q   <= to_cnt_d;
      underrun_q <= underrun_d;
      s1_q       <= s1_d;
      s1_vld_q   <= s1_vld_d;
      s2_q       <= s2_d;
      s2_vld_q   <= s2_vld_d;
      u_q        <= u_d;
      acc_q      <= acc_d;
      d_q        <= d_d;
    end
  end

  assign d_out        = d_q;
  assign underrun_out = underrun_q;

endmodule

// File: tb/tb_pdm_output_stage.sv
// Directed bench for pdm_output_stage: ramp, pipeline latency, saturation,
// sigma-delta density, underrun and asynchronous reset behaviour.
module tb_pdm_output_stage;
  localparam int unsigned NCH       = 2;
  localparam int unsigned WIDTH     = 16;
  localparam int unsigned VOL_WIDTH = 8;
  localparam int unsigned RAMP_DIV  = 4;
  localparam int unsigned TIMEOUT   = 1000;

  logic                  clk_in = 1'b0;
  logic                  rst_n_in;
  logic [NCH*WIDTH-1:0]  sample_in;
  logic                  valid_in;
  logic [VOL_WIDTH-1:0]  vol_in;
  logic                  mute_in;
  logic [NCH-1:0]        d_out;
  logic                  underrun_out;

  int n_checks = 0;
  int n_pass   = 0;
  int ones0    = 0;
  int ones1    = 0;

  pdm_output_stage #(
    .NCH(NCH), .WIDTH(WIDTH), .VOL_WIDTH(VOL_WIDTH),
    .RAMP_DIV(RAMP_DIV), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .sample_in(sample_in),
    .valid_in(valid_in), .vol_in(vol_in), .mute_in(mute_in),
    .d_out(d_out), .underrun_out(underrun_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp, input int unsigned tol = 0);
    int diff;
    n_checks++;
    diff = int'(got) - int'(exp);
    if (!$isunknown(got) && diff <= int'(tol) && -diff <= int'(tol)) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (tol %0d)", tag, got, exp, tol);
  endtask

  // One clock; outputs are observed 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk_in);
    #1;
    ones0 += int'(d_out[0]);
    ones1 += int'(d_out[1]);
  endtask

  // n cycles; with ka set, re-strobe the held sample every 256 cycles.
  task automatic run(input int n, input bit ka);
    for (int i = 0; i < n; i++) begin
      valid_in = ka && (i % 256 == 0);
      step();
    end
    valid_in = 1'b0;
  endtask

  task automatic send(input logic [WIDTH-1:0] c1, input logic [WIDTH-1:0] c0);
    sample_in = {c1, c0};
    valid_in  = 1'b1;
    step();
    valid_in  = 1'b0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n_in  = 1'b0;
    valid_in  = 1'b0;
    sample_in = '0;
    vol_in    = 8'd128;
    mute_in   = 1'b0;
    repeat (3) step();
    check("rst_dout", 32'(d_out), 0);
    check("rst_underrun", 32'(underrun_out), 0);
    check("rst_g", 32'(dut.g_q), 0);
    check("rst_u0", 32'(dut.u_q[0]), 32'h8000);
    check("rst_u1", 32'(dut.u_q[1]), 32'h8000);

    rst_n_in = 1'b1;
    repeat (4) step();
    check("ramp_g_4", 32'(dut.g_q), 1);
    repeat (508) step();
    check("ramp_g_512", 32'(dut.g_q), 128);
    repeat (487) step();
    check("underrun_999", 32'(underrun_out), 0);
    step();
    check("underrun_1000", 32'(underrun_out), 1);
    check("underrun_u0", 32'(dut.u_q[0]), 32'h8000);

    // Recovery from underrun.
    send(16'h1000, 16'h2000);
    check("rec_underrun_clr", 32'(underrun_out), 0);
    step();
    check("rec_u0_hold", 32'(dut.u_q[0]), 32'h8000);
    step();
    check("rec_u0", 32'(dut.u_q[0]), 32'hA000);
    check("rec_u1", 32'(dut.u_q[1]), 32'h9000);

    // Valid strobe on the cycle the count would reach TIMEOUT.
    repeat (997) step();
    check("pre_wins_999", 32'(underrun_out), 0);
    send(16'h1000, 16'h2000);
    check("valid_wins", 32'(underrun_out), 0);
    step();
    check("valid_wins_next", 32'(underrun_out), 0);

    // Back-to-back samples.
    for (int i = 0; i < 12; i++) begin
      valid_in  = (i < 10);
      sample_in = {16'(32'hFF00 - i), 16'(32'h0100 + i)};
      step();
      if (i >= 2) begin
        check($sformatf("b2b_u0_%0d", i), 32'(dut.u_q[0]), 32'(32'h8100 + i - 2));
        check($sformatf("b2b_u1_%0d", i), 32'(dut.u_q[1]), 32'(32'h7F00 - i + 2));
      end
    end
    valid_in = 1'b0;

    // Full gain and saturation.
    vol_in = 8'd255;
    run(508, 1'b1);
    check("g_255", 32'(dut.g_q), 255);
    run(20, 1'b1);
    check("g_no_wrap", 32'(dut.g_q), 255);
    send(16'h8000, 16'h7FFF);
    step();
    step();
    check("sat_pos_u0", 32'(dut.u_q[0]), 32'hFFFF);
    check("sat_neg_u1", 32'(dut.u_q[1]), 32'h0000);
    step();
    step();
    ones1 = 0;
    run(200, 1'b1);
    check("sat_neg_dout1", 32'(ones1), 0);

    // Stall with live data forces midscale; gain ramps down meanwhile.
    vol_in = 8'd128;
    run(1000, 1'b0);
    check("underrun2", 32'(underrun_out), 1);
    check("underrun2_u0", 32'(dut.u_q[0]), 32'h8000);
    check("underrun2_u1", 32'(dut.u_q[1]), 32'h8000);
    check("g_down_128", 32'(dut.g_q), 128);

    // Density at g=128.
    send(16'h0000, 16'h4000);
    step();
    step();
    check("dens_u0", 32'(dut.u_q[0]), 32'hC000);
    check("dens_u1", 32'(dut.u_q[1]), 32'h8000);
    step();
    step();
    ones0 = 0;
    ones1 = 0;
    run(65536, 1'b1);
    check("dens0_075", 32'(ones0), 49152, 1);
    check("dens1_050", 32'(ones1), 32768, 1);

    // Mute ramp down and back up.
    mute_in = 1'b1;
    run(256, 1'b1);
    check("mute_g_256", 32'(dut.g_q), 64);
    run(256, 1'b1);
    check("mute_g_512", 32'(dut.g_q), 0);
    send(16'h0000, 16'h4000);
    step();
    step();
    check("mute_u0", 32'(dut.u_q[0]), 32'h8000);
    step();
    step();
    ones0 = 0;
    ones1 = 0;
    run(4096, 1'b1);
    check("mute_dens0", 32'(ones0), 2048, 1);
    check("mute_dens1", 32'(ones1), 2048, 1);
    mute_in = 1'b0;
    run(512, 1'b1);
    check("unmute_g_512", 32'(dut.g_q), 128);

    // Asynchronous reset with a sample sitting in S2.
    send(16'h7F00, 16'h7F00);
    run(10, 1'b0);
    send(16'h0000, 16'h1234);
    step();
    check("pre_rst_u0", 32'(dut.u_q[0]), 32'hFF00);
    #2 rst_n_in = 1'b0;
    #1;
    check("async_rst_dout", 32'(d_out), 0);
    check("async_rst_underrun", 32'(underrun_out), 0);
    check("async_rst_g", 32'(dut.g_q), 0);
    check("async_rst_u0", 32'(dut.u_q[0]), 32'h8000);
    #1 rst_n_in = 1'b1;
    repeat (3) step();
    check("rst_discard_u0", 32'(dut.u_q[0]), 32'h8000);
    check("rst_discard_u1", 32'(dut.u_q[1]), 32'h8000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
